// File: rtl/start_delay_pkg.sv
// ============================================================================
// Module      : start_delay_pkg
// Description : Shared types and constants for the start-alignment delay gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package start_delay_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, ACTIVE, HOLD} dly_state_t;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/start_delay_ch.sv
// ============================================================================
// Module      : start_delay_ch
// Description : One channel: down-counter delay from serializer start to
//               deserializer enable, level or pulse mode, latched at load.
//               START_DELAY_STATUS_EN adds live counter and abort pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module start_delay_ch
  import start_delay_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic             pulse_i,
  output logic             des_o,
  output logic             busy_o
`ifdef START_DELAY_STATUS_EN
  ,
  output logic [CNT_W-1:0] cnt_o,
  output logic             abort_o
`endif
);

  dly_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             des_q;
  logic             busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          // Zero delay behaves as one cycle.
          cnt_d   = (delay_i == '0) ? '0 : delay_i - CNT_W'(1);
          mode_d  = pulse_i;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (!start_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (!start_i) begin
          state_d = IDLE;
        end else if (mode_q == MODE_PULSE) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!start_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_LEVEL;
      des_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      des_q   <= (state_d == ACTIVE);
      busy_q  <= (state_d == COUNT);
    end
  end

  assign des_o  = des_q;
  assign busy_o = busy_q;

`ifdef START_DELAY_STATUS_EN
  logic abort_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= (state_q == COUNT) && !start_i;
    end
  end

  assign cnt_o   = cnt_q;
  assign abort_o = abort_q;
`endif

endmodule

`default_nettype wire

// File: rtl/start_delay_gen.sv
// ============================================================================
// Module      : start_delay_gen
// Description : Multi-channel programmable start-alignment delay with per-
//               channel config registers. START_DELAY_STATUS_EN adds the
//               cnt_dbg and err_abort status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module start_delay_gen
  import start_delay_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 8,
  parameter int DEFAULT_DELAY = 47,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] serializer_start,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic              cfg_pulse,
  output logic [NUM_CH-1:0] deserializer_start,
  output logic [NUM_CH-1:0] busy
`ifdef START_DELAY_STATUS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] cnt_dbg,
  output logic [NUM_CH-1:0]       err_abort
`endif
);

  logic [CNT_W-1:0] delay_cfg_q [NUM_CH];
  logic             mode_cfg_q  [NUM_CH];

  // Out-of-range channel indices never match, so such writes are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        delay_cfg_q[i] <= CNT_W'(DEFAULT_DELAY);
        mode_cfg_q[i]  <= MODE_LEVEL;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ch == CH_W'(i)) begin
          delay_cfg_q[i] <= cfg_delay;
          mode_cfg_q[i]  <= cfg_pulse;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef START_DELAY_STATUS_EN
    start_delay_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .start_i (serializer_start[i]),
      .delay_i (delay_cfg_q[i]),
      .pulse_i (mode_cfg_q[i]),
      .des_o   (deserializer_start[i]),
      .busy_o  (busy[i]),
      .cnt_o   (cnt_dbg[i*CNT_W +: CNT_W]),
      .abort_o (err_abort[i])
    );
`else
    start_delay_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .start_i (serializer_start[i]),
      .delay_i (delay_cfg_q[i]),
      .pulse_i (mode_cfg_q[i]),
      .des_o   (deserializer_start[i]),
      .busy_o  (busy[i])
    );
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_start_delay_gen.sv
// ============================================================================
// Module      : tb_start_delay_gen
// Description : Scoreboard bench for start_delay_gen; expected output edges
//               are queued by stimulus and matched by an edge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_start_delay_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] serializer_start;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_delay;
  logic              cfg_pulse;
  logic [NUM_CH-1:0] deserializer_start;
  logic [NUM_CH-1:0] busy;
`ifdef START_DELAY_STATUS_EN
  logic [NUM_CH*CNT_W-1:0] cnt_dbg;
  logic [NUM_CH-1:0]       err_abort;
`endif

  start_delay_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DELAY(47)) dut (
    .clk                (clk),
    .reset              (reset),
    .serializer_start   (serializer_start),
    .cfg_we             (cfg_we),
    .cfg_ch             (cfg_ch),
    .cfg_delay          (cfg_delay),
    .cfg_pulse          (cfg_pulse),
    .deserializer_start (deserializer_start),
    .busy               (busy)
`ifdef START_DELAY_STATUS_EN
    ,
    .cnt_dbg            (cnt_dbg),
    .err_abort          (err_abort)
`endif
  );

  always #5 clk = ~clk;

  // cyc == n after the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int lvl;
  } ev_t;

  ev_t exp_q [NUM_CH][$];
  int  n_checks = 0;
  int  n_errors = 0;
  logic [NUM_CH-1:0] prev_des = '0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int ch, input int c, input int l);
    ev_t e;
    e.cyc = c;
    e.lvl = l;
    exp_q[ch].push_back(e);
  endtask

  // Monitor: every deserializer_start transition must match the next queued event.
  always @(negedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (deserializer_start[ch] !== prev_des[ch]) begin
        if (exp_q[ch].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_edge ch%0d: got level %0b at cycle %0d, required no edge",
                   ch, deserializer_start[ch], cyc);
        end else begin
          ev_t e;
          e = exp_q[ch].pop_front();
          check($sformatf("edge_cycle_ch%0d", ch), cyc, e.cyc);
          check($sformatf("edge_level_ch%0d", ch), int'(deserializer_start[ch]), e.lvl);
        end
      end
    end
    prev_des = deserializer_start;
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called at a falling edge; start is sampled at the next rising edge k.
  task automatic start_ch(input int ch, input int d, input bit pulse, output int k);
    serializer_start[ch] = 1'b1;
    k = cyc + 1;
    push_ev(ch, k + d, 1);
    if (pulse) push_ev(ch, k + d + 1, 0);
  endtask

  task automatic stop_ch(input int ch, input bit expect_fall);
    serializer_start[ch] = 1'b0;
    if (expect_fall) push_ev(ch, cyc + 1, 0);
  endtask

  task automatic cfg_write(input int ch, input int d, input bit p);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_delay = CNT_W'(d);
    cfg_pulse = p;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    reset            = 1'b1;
    serializer_start = '0;
    cfg_we           = 1'b0;
    cfg_ch           = '0;
    cfg_delay        = '0;
    cfg_pulse        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_des", int'(deserializer_start), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;

    // Default delay, level mode on ch0.
    @(negedge clk);
    start_ch(0, 47, 1'b0, k);
    wait_until(k);
    check("t1_busy_first", int'(busy[0]), 1);
    wait_until(k + 46);
    check("t1_busy_last", int'(busy[0]), 1);
    check("t1_des_early", int'(deserializer_start[0]), 0);
    wait_until(k + 47);
    check("t1_busy_done", int'(busy[0]), 0);
    check("t1_des_on", int'(deserializer_start[0]), 1);
    check("t1_others_idle", int'(deserializer_start[3:1]), 0);
    wait_until(k + 52);
    stop_ch(0, 1'b1);
    wait_until(cyc + 3);

    // Pulse mode, delay 5 on ch1; one pulse per assertion.
    cfg_write(1, 5, 1'b1);
    start_ch(1, 5, 1'b1, k);
    wait_until(k + 20);
    stop_ch(1, 1'b0);
    wait_until(cyc + 3);
    start_ch(1, 5, 1'b1, k);
    wait_until(k + 8);
    stop_ch(1, 1'b0);
    wait_until(cyc + 2);

    // Abort on ch2 then full recount.
    serializer_start[2] = 1'b1;
    k = cyc + 1;
    wait_until(k + 29);
    check("t3_busy_mid", int'(busy[2]), 1);
    serializer_start[2] = 1'b0;
    wait_until(cyc + 1);
    check("t3_busy_abort", int'(busy[2]), 0);
    wait_until(cyc + 2);
    start_ch(2, 47, 1'b0, k);
    wait_until(k + 46);
    check("t3_restart_early", int'(deserializer_start[2]), 0);
    wait_until(k + 49);
    stop_ch(2, 1'b1);
    wait_until(cyc + 3);

    // ch3 boundary delays 0, 1, 255.
    cfg_write(3, 0, 1'b0);
    start_ch(3, 1, 1'b0, k);
    wait_until(k + 3);
    stop_ch(3, 1'b1);
    wait_until(cyc + 2);
    cfg_write(3, 1, 1'b0);
    start_ch(3, 1, 1'b0, k);
    wait_until(k + 3);
    stop_ch(3, 1'b1);
    wait_until(cyc + 2);
    cfg_write(3, 255, 1'b0);
    start_ch(3, 255, 1'b0, k);
    wait_until(k + 254);
    check("t4_d255_early", int'(deserializer_start[3]), 0);
    wait_until(k + 255);
    check("t4_d255_on", int'(deserializer_start[3]), 1);
    wait_until(k + 257);
    stop_ch(3, 1'b1);
    wait_until(cyc + 2);

    // Write and start in the same edge: old delay for this load.
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_ch    = 2'd0;
    cfg_delay = 8'd10;
    cfg_pulse = 1'b0;
    start_ch(0, 47, 1'b0, k);
    @(negedge clk);
    cfg_we = 1'b0;
    wait_until(k + 49);
    stop_ch(0, 1'b1);
    wait_until(cyc + 2);
    start_ch(0, 10, 1'b0, k);
    wait_until(k + 12);
    stop_ch(0, 1'b1);
    wait_until(cyc + 2);

    // All channels at once, reset mid-count, recount with default config.
    serializer_start = '1;
    k = cyc + 1;
    push_ev(0, k + 10, 1);
    push_ev(1, k + 5, 1);
    push_ev(1, k + 6, 0);
    wait_until(k + 19);
    #2;
    reset = 1'b1;
    push_ev(0, cyc + 1, 0);
    #1;
    check("t6_reset_des", int'(deserializer_start), 0);
    check("t6_reset_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    k = cyc + 1;
    for (int ch = 0; ch < NUM_CH; ch++) push_ev(ch, k + 47, 1);
    wait_until(k + 46);
    check("t6_busy_all", int'(busy), 15);
    wait_until(k + 47);
    check("t6_des_all", int'(deserializer_start), 15);
    wait_until(k + 49);
    serializer_start = '0;
    for (int ch = 0; ch < NUM_CH; ch++) push_ev(ch, cyc + 1, 0);
    wait_until(cyc + 3);

    for (int ch = 0; ch < NUM_CH; ch++)
      check($sformatf("pending_events_ch%0d", ch), exp_q[ch].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
